// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// the hard-wired zero register and the load-use hazard predicate.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX whose result the instruction in ID needs cannot be forwarded in time.
  function automatic logic load_use_hazard(input logic       memread,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt);
    return memread && (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for the hazard sequencer's performance statistics.
module hazard_perf_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/bubble/flush sequencing for the 5-stage pipeline (load-use, taken branch, mul/div wait).
// Define HAZARD_PERF_CNT_EN to build the stall_cycles / flush_events counters.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int              TO_W   = $clog2(MD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MD_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            md_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Still waiting on the mul/div unit: no result yet and the hang limit not reached.
  assign md_hold = (state_q == MD_WAIT) && !md_done && (to_cnt_q != TO_MAX);

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (!ex_branch_taken && ex_md_start) begin
          state_d  = MD_WAIT;
          to_cnt_d = '0;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_MAX) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state_q == RUN) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (ex_md_start) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end else if (load_use_hazard(ex_memread, ex_rd, id_rs, id_rt)) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else if (md_hold) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end
  end

  assign md_timeout = timeout_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             branch_flush;

  assign branch_flush = !rst && (state_q == RUN) && ex_branch_taken;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (!pc_en),
    .count_o (stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (branch_flush),
    .count_o (flush_cnt)
  );

  assign stall_cycles = rst ? '0 : stall_cnt;
  assign flush_events = rst ? '0 : flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer against a cycle-level behavioural model.
module tb_hazard_sequencer;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             ex_memread, ex_branch_taken, ex_md_start, md_done;
  logic             pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state, in the terms of the description: is a mul/div op pending,
  // how many wait cycles have elapsed, has the unit hung, event tallies.
  bit m_busy;
  int m_waited;
  bit m_hung;
  int m_stalls;
  int m_flushes;

  hazard_sequencer #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .md_done         (md_done),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .md_timeout      (md_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  // Expected {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_timeout}.
  function automatic logic [6:0] model_out();
    bit pc = 1, ifid = 1, idex = 1, ifl = 0, idfl = 0, exfl = 0;
    bit lu;
    if (rst) return 7'b0001110;
    lu = ex_memread && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    if (!m_busy) begin
      if (ex_branch_taken) begin ifl = 1; idfl = 1; end
      else if (ex_md_start) begin pc = 0; ifid = 0; idex = 0; exfl = 1; end
      else if (lu) begin pc = 0; ifid = 0; idfl = 1; end
    end else if (!md_done && m_waited < MD_TIMEOUT) begin
      pc = 0; ifid = 0; idex = 0; exfl = 1;
    end
    return {pc, ifid, idex, ifl, idfl, exfl, m_hung};
  endfunction

  function automatic logic [2*CNT_W-1:0] model_cnt();
    if (rst) return '0;
`ifdef HAZARD_PERF_CNT_EN
    return {CNT_W'(m_stalls), CNT_W'(m_flushes)};
`else
    return '0;
`endif
  endfunction

  task automatic model_advance(input bit pc_en_exp);
    if (rst) begin
      m_busy = 0; m_waited = 0; m_hung = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!pc_en_exp && m_stalls < CNT_MAX) m_stalls++;
      if (!m_busy && ex_branch_taken && m_flushes < CNT_MAX) m_flushes++;
      if (!m_busy) begin
        if (!ex_branch_taken && ex_md_start) begin m_busy = 1; m_waited = 0; end
      end else if (md_done) m_busy = 0;
      else if (m_waited == MD_TIMEOUT) begin m_busy = 0; m_hung = 1; end
      else m_waited++;
    end
  endtask

  // Samples one cycle mid-period, returns observed and modelled values, then crosses the edge.
  task automatic run_cycle(output logic [6:0] got, output logic [6:0] exp,
                           output logic [2*CNT_W-1:0] gotc, output logic [2*CNT_W-1:0] expc);
    @(negedge clk);
    exp  = model_out();
    expc = model_cnt();
    got  = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_timeout};
    gotc = {stall_cycles, flush_events};
    model_advance(exp[6]);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; id_rs = 5'd1; id_rt = 5'd2; ex_rd = 5'd3;
    ex_memread = 0; ex_branch_taken = 0; ex_md_start = 0; md_done = 0;
  endtask

  task automatic test_reset();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    for (int i = 0; i < 3; i++) begin
      rst = 1; id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rd = 5'($urandom);
      ex_memread = 1'($urandom); ex_branch_taken = 1'($urandom);
      ex_md_start = 1'($urandom); md_done = 1'($urandom);
      run_cycle(g, e, gc, ec);
      n_cmp++;
      if (g !== 7'b0001110) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", g, 7'b0001110); end
      if (i > 0) begin
        n_cmp++;
        if (gc !== '0) begin n_fail++; $display("FAIL reset_counters: got %h expected 0", gc); end
      end
    end
    set_idle();
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if (g !== 7'b1110000) begin n_fail++; $display("FAIL reset_release: got %b expected %b", g, 7'b1110000); end
  endtask

  task automatic test_load_use();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    set_idle(); ex_memread = 1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if (g !== 7'b0010100) begin n_fail++; $display("FAIL load_use_hit: got %b expected %b", g, 7'b0010100); end
    set_idle();
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if (g !== 7'b1110000) begin n_fail++; $display("FAIL load_use_single_bubble: got %b expected %b", g, 7'b1110000); end
    set_idle(); ex_memread = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if (g !== 7'b1110000) begin n_fail++; $display("FAIL load_use_r0: got %b expected %b", g, 7'b1110000); end
    for (int i = 0; i < 40; i++) begin
      set_idle(); ex_memread = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      run_cycle(g, e, gc, ec);
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL load_use_rand[%0d]: got %b/%h expected %b/%h", i, g, gc, e, ec); end
    end
  endtask

  task automatic test_branch_load_use();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    logic [CNT_W-1:0] fl_before;
    set_idle(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 5'd7; id_rt = 5'd7; ex_md_start = 1;
    run_cycle(g, e, gc, ec);
    fl_before = gc[CNT_W-1:0];
    n_cmp++;
    if (g !== 7'b1111100) begin n_fail++; $display("FAIL branch_over_load_use: got %b expected %b", g, 7'b1111100); end
    set_idle();
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL branch_md_ignored: got %b/%h expected %b/%h", g, gc, e, ec); end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if (gc[CNT_W-1:0] !== CNT_W'(fl_before + 1'b1) && fl_before != CNT_MAX[CNT_W-1:0]) begin
      n_fail++; $display("FAIL branch_flush_count: got %0d expected %0d", gc[CNT_W-1:0], fl_before + 1);
    end
`endif
  endtask

  task automatic test_md_op();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    int stalls = 0;
    for (int c = 0; c < 6; c++) begin
      set_idle();
      ex_md_start     = (c == 0);
      md_done         = (c == 5);
      ex_branch_taken = (c == 2);
      ex_memread = (c == 3); ex_rd = 5'd4; id_rs = 5'd4;
      run_cycle(g, e, gc, ec);
      if (!g[6]) stalls++;
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL md_op[%0d]: got %b/%h expected %b/%h", c, g, gc, e, ec); end
      if (c < 5) begin
        n_cmp++;
        if (g[1] !== 1'b1) begin n_fail++; $display("FAIL md_exmem_flush[%0d]: got %b expected 1", c, g[1]); end
      end
    end
    n_cmp++;
    if (stalls != 5) begin n_fail++; $display("FAIL md_stall_len: got %0d expected 5", stalls); end
    set_idle(); md_done = 1; ex_memread = 1; ex_rd = 5'd6; id_rt = 5'd6;
    run_cycle(g, e, gc, ec);
    n_cmp++;
    if (g !== 7'b0010100) begin n_fail++; $display("FAIL md_back_in_run: got %b expected %b", g, 7'b0010100); end
  endtask

  task automatic test_timeout();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    int stalls = 0;
    for (int c = 0; c < 13; c++) begin
      set_idle(); ex_md_start = (c == 0);
      run_cycle(g, e, gc, ec);
      if (!g[6]) stalls++;
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL timeout[%0d]: got %b/%h expected %b/%h", c, g, gc, e, ec); end
    end
    n_cmp++;
    if (stalls != MD_TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_stall_len: got %0d expected %0d", stalls, MD_TIMEOUT + 1); end
    n_cmp++;
    if (g !== 7'b1110001) begin n_fail++; $display("FAIL timeout_flag: got %b expected %b", g, 7'b1110001); end
  endtask

  task automatic test_reset_mid_wait();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    for (int c = 0; c < 6; c++) begin
      set_idle();
      ex_md_start = (c == 0);
      rst = (c == 3 || c == 4);
      run_cycle(g, e, gc, ec);
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL rst_mid_wait[%0d]: got %b/%h expected %b/%h", c, g, gc, e, ec); end
    end
    n_cmp++;
    if ({g, gc} !== {7'b1110000, {2*CNT_W{1'b0}}}) begin
      n_fail++; $display("FAIL rst_mid_wait_run: got %b/%h expected 1110000/0", g, gc);
    end
  endtask

  task automatic test_counters();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    set_idle(); rst = 1;
    run_cycle(g, e, gc, ec);
    for (int c = 0; c < 20; c++) begin
      set_idle(); ex_memread = 1; ex_rd = 5'd12; id_rs = 5'd12;
      run_cycle(g, e, gc, ec);
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL counters[%0d]: got %b/%h expected %b/%h", c, g, gc, e, ec); end
    end
    set_idle();
    run_cycle(g, e, gc, ec);
    n_cmp++;
`ifdef HAZARD_PERF_CNT_EN
    if (gc[2*CNT_W-1:CNT_W] !== CNT_W'(15)) begin n_fail++; $display("FAIL stall_saturate: got %0d expected 15", gc[2*CNT_W-1:CNT_W]); end
`else
    if (gc !== '0) begin n_fail++; $display("FAIL counters_absent: got %h expected 0", gc); end
`endif
  endtask

  task automatic test_random();
    logic [6:0] g, e; logic [2*CNT_W-1:0] gc, ec;
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_md_start     = ($urandom_range(0, 9) == 0);
      md_done         = ($urandom_range(0, 5) == 0);
      ex_memread      = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      run_cycle(g, e, gc, ec);
      n_cmp++;
      if ({g, gc} !== {e, ec}) begin n_fail++; $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, g, gc, e, ec); end
    end
  endtask

  initial begin
    m_busy = 0; m_waited = 0; m_hung = 0; m_stalls = 0; m_flushes = 0;
    set_idle(); rst = 1;
    #1;
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_md_op();
    test_timeout();
    test_reset_mid_wait();
    test_counters();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
